// File: rtl/elevator_call_scheduler.sv
// Elevator car sequencer: call bitmap, SCAN direction choice, travel/door timing.
// Optional EMERGENCY_STOP_EN adds an estop input and a HALT state that freezes MOVE/DOOR.
//  state  | meaning
//  IDLE   | car parked, door closed, waiting for a pending call
//  MOVE   | motor on in down_up_flag direction, timer counts one floor of travel
//  DOOR   | car stopped with door open, timer counts dwell
//  HALT   | (estop build) motors off, timer frozen, resumes the interrupted state
module elevator_call_scheduler #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  call_valid,
  input  logic [2:0]            call_floor,
`ifdef EMERGENCY_STOP_EN
  input  logic                  estop,
`endif
  output logic                  call_ack,
  output logic [2:0]            actual_floor,
  output logic                  down_up_flag,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] T_TRAVEL = TW'(TRAVEL_CYCLES);
  localparam logic [TW-1:0] T_DOOR   = TW'(DOOR_CYCLES);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [2:0]    TOP      = 3'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
`ifdef EMERGENCY_STOP_EN
    S_HALT = 2'd3,
`endif
    S_DOOR = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    ack_q, ack_d;
`ifdef EMERGENCY_STOP_EN
  state_t                  ret_q, ret_d;
`endif

  function automatic logic calls_above(input logic [NUM_FLOORS-1:0] p, input logic [2:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i > int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic calls_below(input logic [NUM_FLOORS-1:0] p, input logic [2:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i < int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] v;
    for (int i = 0; i < NUM_FLOORS; i++) v[i] = (3'(i) == f);
    return v;
  endfunction

  logic                  call_ok, call_here, door_like;
  logic                  ahead_cur, behind_cur, ahead_nxt, arrive_hit;
  logic [2:0]            floor_nxt;
  logic [NUM_FLOORS-1:0] call_vec, here_vec, nxt_vec, pend_w;

  always_comb begin
    call_ok   = call_valid && (int'(call_floor) < NUM_FLOORS);
    call_here = call_ok && (call_floor == floor_q);
    call_vec  = call_ok ? onehot(call_floor) : '0;
    here_vec  = onehot(floor_q);
    pend_w    = pending_q | call_vec;
    if (dir_q) floor_nxt = (floor_q < TOP) ? floor_q + 3'd1 : floor_q;
    else       floor_nxt = (floor_q != 3'd0) ? floor_q - 3'd1 : floor_q;
    nxt_vec    = onehot(floor_nxt);
    arrive_hit = |(pend_w & nxt_vec);
    ahead_cur  = dir_q ? calls_above(pending_q, floor_q) : calls_below(pending_q, floor_q);
    behind_cur = dir_q ? calls_below(pending_q, floor_q) : calls_above(pending_q, floor_q);
    ahead_nxt  = dir_q ? calls_above(pend_w, floor_nxt) : calls_below(pend_w, floor_nxt);
    door_like  = (state_q == S_IDLE) || (state_q == S_DOOR);
`ifdef EMERGENCY_STOP_EN
    if (state_q == S_HALT && ret_q == S_DOOR) door_like = 1'b1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    ack_d     = call_ok;
    // A call for the floor the car is standing at with the door available is served, not queued
    pending_d = pending_q | ((call_here && door_like) ? '0 : call_vec);
`ifdef EMERGENCY_STOP_EN
    ret_d     = ret_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (call_here || (|(pending_q & here_vec))) begin
          pending_d = pending_d & ~here_vec;
          state_d   = S_DOOR;
          timer_d   = T_DOOR;
        end else if (|pending_q) begin
          if (!ahead_cur) dir_d = !dir_q;
          state_d = S_MOVE;
          timer_d = T_TRAVEL;
        end
      end
      S_MOVE: begin
`ifdef EMERGENCY_STOP_EN
        if (estop) begin
          state_d = S_HALT;
          ret_d   = S_MOVE;
        end else
`endif
        if (timer_q <= T_ONE) begin
          floor_d = floor_nxt;
          if (arrive_hit) begin
            pending_d = pend_w & ~nxt_vec;
            state_d   = S_DOOR;
            timer_d   = T_DOOR;
          end else if (ahead_nxt) begin
            timer_d = T_TRAVEL;
          end else begin
            state_d = S_IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_DOOR: begin
`ifdef EMERGENCY_STOP_EN
        if (estop) begin
          state_d = S_HALT;
          ret_d   = S_DOOR;
        end else
`endif
        if (call_here) begin
          timer_d = T_DOOR;
        end else if (timer_q <= T_ONE) begin
          if (ahead_cur) begin
            state_d = S_MOVE;
            timer_d = T_TRAVEL;
          end else if (behind_cur) begin
            dir_d   = !dir_q;
            state_d = S_MOVE;
            timer_d = T_TRAVEL;
          end else begin
            state_d = S_IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
`ifdef EMERGENCY_STOP_EN
      S_HALT: begin
        if (!estop) state_d = ret_q;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      floor_q   <= 3'd0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      timer_q   <= '0;
      ack_q     <= 1'b0;
`ifdef EMERGENCY_STOP_EN
      ret_q     <= S_IDLE;
`endif
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
`ifdef EMERGENCY_STOP_EN
      ret_q     <= ret_d;
`endif
    end
  end

  assign call_ack     = ack_q;
  assign actual_floor = floor_q;
  assign down_up_flag = dir_q;
  assign pending      = pending_q;
  assign busy         = (state_q != S_IDLE);
  assign motor_up     = (state_q == S_MOVE) && dir_q;
  assign motor_down   = (state_q == S_MOVE) && !dir_q;
`ifdef EMERGENCY_STOP_EN
  assign door_open    = (state_q == S_DOOR) || (state_q == S_HALT && ret_q == S_DOOR);
`else
  assign door_open    = (state_q == S_DOOR);
`endif

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios plus random calls checked
// against an event-time model of the car (absolute deadlines, call array).
module tb_elevator_call_scheduler;
  localparam int NF = 4;
  localparam int TC = 8;
  localparam int DC = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          call_valid = 1'b0;
  logic [2:0]    call_floor = 3'd0;
  logic          call_ack, down_up_flag, motor_up, motor_down, door_open, busy;
  logic [2:0]    actual_floor;
  logic [NF-1:0] pending;
  logic [12:0]   obs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  elevator_call_scheduler #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .call_valid(call_valid), .call_floor(call_floor),
    .call_ack(call_ack), .actual_floor(actual_floor), .down_up_flag(down_up_flag),
    .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
    .pending(pending), .busy(busy)
  );

  assign obs = {call_ack, actual_floor, down_up_flag, motor_up, motor_down, door_open, pending, busy};

  // Car model: mode 0 parked, 1 travelling, 2 door open; m_end is the edge index
  // at which the current travel leg or dwell finishes.
  int m_mode, m_floor, m_end, m_now;
  bit m_dir, m_ack;
  bit m_pend[NF];

  task automatic model_reset();
    m_mode = 0; m_floor = 0; m_dir = 1'b1; m_ack = 1'b0; m_end = 0; m_now = 0;
    for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
  endtask

  function automatic int count_dir(input bit p[NF], input int f, input bit up);
    int c = 0;
    for (int i = 0; i < NF; i++) if (p[i] && (up ? (i > f) : (i < f))) c++;
    return c;
  endfunction

  task automatic model_edge(input bit cv, input int cf);
    bit old[NF];
    bit ok, here;
    old  = m_pend;
    ok   = cv && (cf < NF);
    here = ok && (cf == m_floor);
    m_ack = ok;
    if (ok && !(here && m_mode != 1)) m_pend[cf] = 1'b1;
    if (m_mode == 0) begin
      if (here) begin
        m_mode = 2; m_end = m_now + DC;
      end else if (count_dir(old, m_floor, 1'b1) + count_dir(old, m_floor, 1'b0) > 0) begin
        if (count_dir(old, m_floor, m_dir) == 0) m_dir = !m_dir;
        m_mode = 1; m_end = m_now + TC;
      end
    end else if (m_mode == 1) begin
      if (m_now == m_end) begin
        m_floor += m_dir ? 1 : -1;
        if (m_pend[m_floor]) begin
          m_pend[m_floor] = 1'b0; m_mode = 2; m_end = m_now + DC;
        end else if (count_dir(m_pend, m_floor, m_dir) > 0) begin
          m_end = m_now + TC;
        end else begin
          m_mode = 0;
        end
      end
    end else begin
      if (here) begin
        m_end = m_now + DC;
      end else if (m_now == m_end) begin
        if (count_dir(old, m_floor, m_dir) > 0) begin
          m_mode = 1; m_end = m_now + TC;
        end else if (count_dir(old, m_floor, !m_dir) > 0) begin
          m_dir = !m_dir; m_mode = 1; m_end = m_now + TC;
        end else begin
          m_mode = 0;
        end
      end
    end
    m_now++;
  endtask

  function automatic logic [12:0] exp_vec();
    logic [NF-1:0] p;
    for (int i = 0; i < NF; i++) p[i] = m_pend[i];
    return {m_ack, 3'(m_floor), m_dir, (m_mode == 1) && m_dir, (m_mode == 1) && !m_dir,
            m_mode == 2, p, m_mode != 0};
  endfunction

  task automatic cyc(input bit cv, input int cf);
    call_valid = cv;
    call_floor = 3'(cf);
    @(posedge clk);
    model_edge(cv, cf);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; call_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 13'b0_000_1_000_0000_0) begin
      bad++; $display("FAIL reset_values obs=%b exp=%b", obs, 13'b0_000_1_000_0000_0);
    end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    cyc(0, 0);
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL reset_idle obs=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_single_trip();
    int m_cnt = 0, d_cnt = 0, f1 = -1, f2 = -1;
    cyc(1, 2);
    total++;
    if (call_ack !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL trip_ack obs=%b exp=%b", obs, exp_vec());
    end
    for (int k = 0; k < 60; k++) begin
      cyc(0, 0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL trip_model k=%0d obs=%b exp=%b", k, obs, exp_vec()); end
      if (actual_floor == 3'd1 && f1 < 0) f1 = m_cnt;
      if (actual_floor == 3'd2 && f2 < 0) f2 = m_cnt;
      if (motor_up) m_cnt++;
      if (door_open) d_cnt++;
      if (!busy) break;
    end
    total++; if (f1 != 8)  begin bad++; $display("FAIL trip_floor1 motor_cycles=%0d exp=8", f1); end
    total++; if (f2 != 16) begin bad++; $display("FAIL trip_floor2 motor_cycles=%0d exp=16", f2); end
    total++; if (d_cnt != 16) begin bad++; $display("FAIL trip_dwell door_cycles=%0d exp=16", d_cnt); end
    total++;
    if (pending !== 4'b0000 || busy !== 1'b0 || actual_floor !== 3'd2) begin
      bad++; $display("FAIL trip_end pending=%b busy=%b floor=%0d exp 0000/0/2", pending, busy, actual_floor);
    end
  endtask

  task automatic test_scan();
    int doors[$];
    int down_floor = -1;
    bit prev_door = 1'b0, seen = 1'b0;
    cyc(1, 0);
    for (int k = 0; k < 80 && busy !== 1'b0 || k == 0; k++) begin
      cyc(0, 0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL scan_home obs=%b exp=%b", obs, exp_vec()); end
    end
    cyc(1, 3);
    for (int k = 0; k < 40; k++) begin
      if (actual_floor == 3'd1) begin seen = 1'b1; break; end
      cyc(0, 0);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL scan_reach1 timeout floor=%0d exp=1", actual_floor); end
    cyc(1, 0);
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL scan_call0 obs=%b exp=%b", obs, exp_vec()); end
    for (int k = 0; k < 150; k++) begin
      cyc(0, 0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL scan_model k=%0d obs=%b exp=%b", k, obs, exp_vec()); end
      if (door_open && !prev_door) doors.push_back(int'(actual_floor));
      if (motor_down && down_floor < 0 && doors.size() == 1) down_floor = int'(actual_floor);
      prev_door = door_open;
      if (!busy) break;
    end
    total++;
    if (doors.size() != 2 || doors[0] != 3 || doors[1] != 0) begin
      bad++; $display("FAIL scan_stops count=%0d exp 2 stops at 3 then 0", doors.size());
    end
    total++;
    if (down_floor != 3) begin bad++; $display("FAIL scan_reverse from=%0d exp=3", down_floor); end
    total++;
    if (actual_floor !== 3'd0 || down_up_flag !== 1'b0) begin
      bad++; $display("FAIL scan_end floor=%0d dir=%b exp 0/0", actual_floor, down_up_flag);
    end
  endtask

  task automatic test_door_extend();
    int d = 0;
    cyc(1, 2);
    for (int k = 0; k < 80; k++) begin
      cyc(0, 0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL ext_travel obs=%b exp=%b", obs, exp_vec()); end
      if (!busy) break;
    end
    cyc(1, 2);
    total++;
    if (door_open !== 1'b1 || motor_up !== 1'b0 || motor_down !== 1'b0 || pending !== 4'b0000 || call_ack !== 1'b1) begin
      bad++; $display("FAIL ext_open obs=%b exp door=1 motors=0 pending=0 ack=1", obs);
    end
    repeat (9) begin
      cyc(0, 0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL ext_dwell obs=%b exp=%b", obs, exp_vec()); end
    end
    cyc(1, 2);
    for (int k = 0; k < 40; k++) begin
      if (!door_open) break;
      d++;
      cyc(0, 0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL ext_model obs=%b exp=%b", obs, exp_vec()); end
    end
    total++;
    if (d != 16) begin bad++; $display("FAIL ext_length door_cycles=%0d exp=16", d); end
  endtask

  task automatic test_bad_floor();
    cyc(1, 5);
    total++;
    if (call_ack !== 1'b0 || pending !== 4'b0000) begin
      bad++; $display("FAIL bad_floor ack=%b pending=%b exp 0/0000", call_ack, pending);
    end
    cyc(1, 1);
    total++;
    if (call_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 ack=%b exp=1", call_ack); end
    cyc(1, 3);
    total++;
    if (call_ack !== 1'b1 || pending !== 4'b1010) begin
      bad++; $display("FAIL b2b_pending ack=%b pending=%b exp 1/1010", call_ack, pending);
    end
    for (int k = 0; k < 200; k++) begin
      cyc(0, 0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL b2b_model obs=%b exp=%b", obs, exp_vec()); end
      if (!busy) break;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      cyc($urandom_range(0, 4) == 0, int'($urandom_range(0, 5)));
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL rand_model k=%0d obs=%b exp=%b", k, obs, exp_vec()); end
    end
    for (int k = 0; k < 300; k++) begin
      cyc(0, 0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL rand_drain obs=%b exp=%b", obs, exp_vec()); end
      if (!busy) break;
    end
  endtask

  task automatic test_reset_mid_move();
    bit seen = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 3);
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0);
      if (actual_floor == 3'd1 && motor_up) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rst_reach timeout floor=%0d exp=1 moving", actual_floor); end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 13'b0_000_1_000_0000_0) begin
      bad++; $display("FAIL rst_mid_move obs=%b exp=%b", obs, 13'b0_000_1_000_0000_0);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 0);
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL rst_after obs=%b exp=%b", obs, exp_vec()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_trip();
    test_scan();
    test_door_extend();
    test_bad_floor();
    test_random();
    test_reset_mid_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
